// File: rtl/ro_deserializer_pkg.sv
// rtl/ro_deserializer_pkg.sv - shared states and field widths for the readout deserializer
package ro_deserializer_pkg;

  typedef enum logic [1:0] {IDLE, SYNC_WAIT, ACCUM} rx_state_t;
  typedef enum logic {EMPTY, DRAIN} drain_state_t;

  localparam int WIN_LEN_W = 16;
  localparam int RO_W      = 2;
  localparam int RO_EV     = 0;
  localparam int RO_POL    = 1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sync clear and look-ahead sum
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         keep_inc,
  input  logic         inc,
  output logic [W-1:0] sum
);

  logic [W-1:0] cnt;

  // sum already contains this cycle's event so a window snapshot can include the final slot
  assign sum = (inc && cnt != {W{1'b1}}) ? cnt + W'(1) : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= (keep_inc && inc) ? W'(1) : '0;
    end else begin
      cnt <= sum;
    end
  end

endmodule

// File: rtl/ro_deserializer.sv
// rtl/ro_deserializer.sv - per-channel event accumulator over framed slots with record drain
module ro_deserializer
  import ro_deserializer_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8
) (
  input  logic                      clk_master,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      frame_sync,
  input  logic [WIN_LEN_W-1:0]      win_len,
  input  logic [RO_W-1:0]           read_out_I,
  input  logic [RO_W-1:0]           read_out_Q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [CNT_W-1:0]          out_ev_I,
  output logic [CNT_W-1:0]          out_pol_I,
  output logic [CNT_W-1:0]          out_ev_Q,
  output logic [CNT_W-1:0]          out_pol_Q,
  output logic                      sync_err,
  output logic                      overrun
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  rx_state_t            state, state_nxt;
  drain_state_t         drain, drain_nxt;
  logic [CH_W-1:0]      slot_cnt, cur_slot;
  logic [WIN_LEN_W-1:0] frame_cnt, cur_frame, win_last;
  logic                 acc_cycle, sync_err_now, win_end, clr_all, keep_inc;
  logic                 xfer, last_xfer, buf_free, take_snap;

  logic [CNT_W-1:0] sum_ev_i  [NUM_CH];
  logic [CNT_W-1:0] sum_pol_i [NUM_CH];
  logic [CNT_W-1:0] sum_ev_q  [NUM_CH];
  logic [CNT_W-1:0] sum_pol_q [NUM_CH];
  logic [CNT_W-1:0] snap_ev_i  [NUM_CH];
  logic [CNT_W-1:0] snap_pol_i [NUM_CH];
  logic [CNT_W-1:0] snap_ev_q  [NUM_CH];
  logic [CNT_W-1:0] snap_pol_q [NUM_CH];

  // cur_slot/cur_frame are the position of the slot sampled at this edge, after any realignment
  always_comb begin
    state_nxt    = state;
    acc_cycle    = 1'b0;
    sync_err_now = 1'b0;
    cur_slot     = slot_cnt;
    cur_frame    = frame_cnt;
    case (state)
      IDLE: state_nxt = SYNC_WAIT;
      SYNC_WAIT: begin
        if (frame_sync) begin
          state_nxt = ACCUM;
          acc_cycle = 1'b1;
          cur_slot  = '0;
          cur_frame = '0;
        end
      end
      ACCUM: begin
        acc_cycle = 1'b1;
        if (frame_sync) begin
          cur_slot = '0;
          if (slot_cnt != '0) begin
            sync_err_now = 1'b1;
            cur_frame    = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt    = IDLE;
      acc_cycle    = 1'b0;
      sync_err_now = 1'b0;
    end
  end

  always_comb begin
    win_last = (win_len == '0) ? '0 : win_len - WIN_LEN_W'(1);
    win_end  = acc_cycle && (cur_slot == LAST_CH) && (cur_frame == win_last);
    clr_all  = !acc_cycle || sync_err_now || win_end;
    keep_inc = acc_cycle && !win_end;
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      frame_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync_err <= sync_err_now;
      if (acc_cycle) begin
        slot_cnt <= cur_slot + CH_W'(1);
        if (win_end) begin
          frame_cnt <= '0;
        end else if (cur_slot == LAST_CH) begin
          frame_cnt <= cur_frame + WIN_LEN_W'(1);
        end else begin
          frame_cnt <= cur_frame;
        end
      end else begin
        slot_cnt  <= '0;
        frame_cnt <= '0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = acc_cycle && (cur_slot == CH_W'(c));
    sat_counter #(.W(CNT_W)) u_ev_i (
      .clk(clk_master), .rst(rst), .clr(clr_all), .keep_inc(keep_inc),
      .inc(hit & read_out_I[RO_EV]), .sum(sum_ev_i[c]));
    sat_counter #(.W(CNT_W)) u_pol_i (
      .clk(clk_master), .rst(rst), .clr(clr_all), .keep_inc(keep_inc),
      .inc(hit & read_out_I[RO_POL]), .sum(sum_pol_i[c]));
    sat_counter #(.W(CNT_W)) u_ev_q (
      .clk(clk_master), .rst(rst), .clr(clr_all), .keep_inc(keep_inc),
      .inc(hit & read_out_Q[RO_EV]), .sum(sum_ev_q[c]));
    sat_counter #(.W(CNT_W)) u_pol_q (
      .clk(clk_master), .rst(rst), .clr(clr_all), .keep_inc(keep_inc),
      .inc(hit & read_out_Q[RO_POL]), .sum(sum_pol_q[c]));
  end

  // the buffer frees up on the edge its last record leaves, so back-to-back windows never overrun
  always_comb begin
    xfer      = (drain == DRAIN) && out_ready;
    last_xfer = xfer && (out_ch == LAST_CH);
    buf_free  = (drain == EMPTY) || last_xfer;
    take_snap = win_end && buf_free;
    drain_nxt = drain;
    if (take_snap) begin
      drain_nxt = DRAIN;
    end else if (last_xfer) begin
      drain_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      drain   <= EMPTY;
      out_ch  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_ev_i[i]  <= '0;
        snap_pol_i[i] <= '0;
        snap_ev_q[i]  <= '0;
        snap_pol_q[i] <= '0;
      end
    end else begin
      drain <= drain_nxt;
      if (win_end && !buf_free) begin
        overrun <= 1'b1;
      end
      if (take_snap) begin
        out_ch <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          snap_ev_i[i]  <= sum_ev_i[i];
          snap_pol_i[i] <= sum_pol_i[i];
          snap_ev_q[i]  <= sum_ev_q[i];
          snap_pol_q[i] <= sum_pol_q[i];
        end
      end else if (xfer) begin
        out_ch <= out_ch + CH_W'(1);
      end
    end
  end

  assign out_valid = (drain == DRAIN);
  assign out_ev_I  = snap_ev_i[out_ch];
  assign out_pol_I = snap_pol_i[out_ch];
  assign out_ev_Q  = snap_ev_q[out_ch];
  assign out_pol_Q = snap_pol_q[out_ch];

endmodule

// File: tb/tb_ro_deserializer.sv
// tb/tb_ro_deserializer.sv - directed self-checking bench for ro_deserializer
module tb_ro_deserializer;

  logic        clk_master = 1'b0;
  logic        rst, en, frame_sync, out_ready;
  logic [15:0] win_len;
  logic [1:0]  read_out_I, read_out_Q;
  logic        out_valid, sync_err, overrun;
  logic [2:0]  out_ch;
  logic [7:0]  out_ev_I, out_pol_I, out_ev_Q, out_pol_Q;

  int total = 0;
  int bad   = 0;
  int exp_ev [8];
  int exp_pol [8];

  always #5 clk_master = ~clk_master;

  ro_deserializer #(.NUM_CH(8), .CNT_W(8)) dut (
    .clk_master(clk_master), .rst(rst), .en(en), .frame_sync(frame_sync),
    .win_len(win_len), .read_out_I(read_out_I), .read_out_Q(read_out_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_ev_I(out_ev_I), .out_pol_I(out_pol_I), .out_ev_Q(out_ev_Q),
    .out_pol_Q(out_pol_Q), .sync_err(sync_err), .overrun(overrun)
  );

  task automatic step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_rec(input string tag, input int ch, input int ei, input int pi,
                         input int eq, input int pq);
    string s;
    s = $sformatf("%s.ch%0d", tag, ch);
    chk({s, ".valid"}, out_valid, 1);
    chk({s, ".ch"}, out_ch, ch);
    chk({s, ".ev_I"}, out_ev_I, ei);
    chk({s, ".pol_I"}, out_pol_I, pi);
    chk({s, ".ev_Q"}, out_ev_Q, eq);
    chk({s, ".pol_Q"}, out_pol_Q, pq);
  endtask

  task automatic drain_all(input string tag, input int ei, input int pi, input int eq, input int pq);
    for (int c = 0; c < 8; c++) begin
      chk_rec(tag, c, ei, pi, eq, pq);
      step();
    end
    chk({tag, ".done"}, out_valid, 0);
  endtask

  task automatic sync_frame(input logic [1:0] ri, input logic [1:0] rq);
    read_out_I = ri;
    read_out_Q = rq;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    repeat (7) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nrec;
    rst = 1'b1; en = 1'b0; frame_sync = 1'b0; out_ready = 1'b1;
    win_len = 16'd1; read_out_I = 2'b00; read_out_Q = 2'b00;
    step(); step();
    chk("rst.valid", out_valid, 0);
    chk("rst.ch", out_ch, 0);
    chk("rst.ev_I", out_ev_I, 0);
    chk("rst.pol_Q", out_pol_Q, 0);
    chk("rst.sync_err", sync_err, 0);
    chk("rst.overrun", overrun, 0);
    rst = 1'b0;

    // single hit on slot 3, one-frame window
    en = 1'b1;
    step();
    for (int s = 0; s < 8; s++) begin
      frame_sync = (s == 0);
      read_out_I = (s == 3) ? 2'b11 : 2'b00;
      step();
    end
    frame_sync = 1'b0; read_out_I = 2'b00; en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk_rec("t1", c, (c == 3), (c == 3), 0, 0);
      step();
    end
    chk("t1.done", out_valid, 0);

    // win_len=0 behaves as one frame
    win_len = 16'd0; en = 1'b1;
    step();
    sync_frame(2'b01, 2'b00);
    en = 1'b0; read_out_I = 2'b00;
    drain_all("t_wl0", 1, 0, 0, 0);

    // saturation over a 300-frame window
    win_len = 16'd300; en = 1'b1;
    step();
    read_out_Q = 2'b01; frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    n = 0;
    while (!out_valid && n < 3000) begin
      step();
      n++;
    end
    chk("t2.found", out_valid, 1);
    chk("t2.latency", n, 2399);
    en = 1'b0; read_out_Q = 2'b00;
    drain_all("t2", 0, 0, 255, 0);

    // misaligned frame_sync at slot 5 of frame 2 restarts the window
    win_len = 16'd4; en = 1'b1;
    step();
    read_out_I = 2'b01; frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    repeat (20) step();
    frame_sync = 1'b1;
    step();
    chk("t3.sync_err", sync_err, 1);
    frame_sync = 1'b0;
    step();
    chk("t3.sync_err_pulse", sync_err, 0);
    repeat (29) step();
    chk("t3.not_early", out_valid, 0);
    step();
    chk("t3.window_end", out_valid, 1);
    en = 1'b0; read_out_I = 2'b00;
    drain_all("t3", 4, 0, 0, 0);

    // stalled consumer: second window dropped, first held intact
    win_len = 16'd1; en = 1'b1;
    step();
    sync_frame(2'b01, 2'b00);
    out_ready = 1'b0;
    chk("t4.valid", out_valid, 1);
    read_out_I = 2'b10;
    repeat (7) step();
    chk("t4.no_overrun_yet", overrun, 0);
    step();
    chk("t4.overrun", overrun, 1);
    chk("t4.hold_ch", out_ch, 0);
    chk("t4.hold_ev_I", out_ev_I, 1);
    chk("t4.hold_pol_I", out_pol_I, 0);
    en = 1'b0; read_out_I = 2'b00;
    repeat (4) step();
    chk("t4.still_valid", out_valid, 1);
    chk("t4.still_ch", out_ch, 0);
    out_ready = 1'b1;
    drain_all("t4", 1, 0, 0, 0);
    chk("t4.sticky", overrun, 1);

    // reset in the middle of a drain
    en = 1'b1;
    step();
    sync_frame(2'b00, 2'b11);
    en = 1'b0; read_out_Q = 2'b00;
    repeat (4) step();
    chk("t5.at_ch4", out_ch, 4);
    chk("t5.ev_Q", out_ev_Q, 1);
    rst = 1'b1;
    step();
    chk("t5.rst_valid", out_valid, 0);
    chk("t5.rst_overrun", overrun, 0);
    chk("t5.rst_ch", out_ch, 0);
    chk("t5.rst_ev_Q", out_ev_Q, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("t5.no_record", out_valid, 0);
    en = 1'b1;
    step();
    read_out_I = 2'b01; frame_sync = 1'b1;
    step();
    read_out_I = 2'b00; frame_sync = 1'b0;
    repeat (7) step();
    en = 1'b0;
    chk_rec("t5n", 0, 1, 0, 0, 0);
    step();
    chk_rec("t5n", 1, 0, 0, 0, 0);
    repeat (7) step();
    chk("t5n.done", out_valid, 0);

    // back-to-back windows: snapshot on the last-transfer edge
    en = 1'b1;
    step();
    sync_frame(2'b01, 2'b00);
    for (int k = 0; k < 8; k++) begin
      chk_rec("t6a", k, 1, 0, 0, 0);
      read_out_I = 2'b00; read_out_Q = 2'b01;
      step();
    end
    chk_rec("t6b", 0, 0, 0, 1, 0);
    chk("t6.no_overrun", overrun, 0);
    en = 1'b0; read_out_Q = 2'b00;
    step();
    for (int k = 1; k < 8; k++) begin
      chk_rec("t6b", k, 0, 0, 1, 0);
      step();
    end
    chk("t6.done", out_valid, 0);
    chk("t6.no_overrun_end", overrun, 0);

    // two-frame window with a random-ready consumer against a running model
    for (int c = 0; c < 8; c++) begin
      exp_ev[c] = 0;
      exp_pol[c] = 0;
    end
    win_len = 16'd2; en = 1'b1;
    step();
    for (int t = 0; t < 16; t++) begin
      frame_sync = (t == 0);
      read_out_I = {(t % 5 == 0), (t % 3 == 0)};
      if (t % 3 == 0) exp_ev[t % 8]++;
      if (t % 5 == 0) exp_pol[t % 8]++;
      step();
    end
    en = 1'b0; frame_sync = 1'b0; read_out_I = 2'b00;
    nrec = 0;
    for (int cyc = 0; cyc < 300 && nrec < 8; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk($sformatf("t7.ch%0d.order", nrec), out_ch, nrec);
        chk($sformatf("t7.ch%0d.ev_I", nrec), out_ev_I, exp_ev[nrec]);
        chk($sformatf("t7.ch%0d.pol_I", nrec), out_pol_I, exp_pol[nrec]);
        nrec++;
      end
      step();
    end
    chk("t7.records", nrec, 8);
    chk("t7.done", out_valid, 0);
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_deserializer.md
RO_DESERIALIZER -- requirements
Module: ro_deserializer

Interface
REQ-001 Parameters SHALL be: NUM_CH, 8, channel slots per readout frame (power of 2, 2..64); CNT_W, 8, accumulator width per count.
REQ-002 Clocking and reset SHALL be: one clock, clk_master; reset rst, synchronous and active-high.
REQ-003 Ports SHALL be (name  direction  width  meaning):
 clk_master  in  1  slot clock, one channel slot per rising edge
 rst  in  1  synchronous active-high reset
 en  in  1  receiver enable; 0 forces IDLE at the next edge
 frame_sync  in  1  marks slot 0 of a frame
 win_len  in  16  frames per accumulation window; 0 treated as 1
 read_out_I  in  2  [0] event bit, [1] polarity-event bit, I path
 read_out_Q  in  2  [0] event bit, [1] polarity-event bit, Q path
 out_valid  out  1  record available
 out_ready  in  1  consumer accepts record
 out_ch  out  log2(NUM_CH)  channel index of record
 out_ev_I, out_pol_I, out_ev_Q, out_pol_Q  out  CNT_W each  window counts
 sync_err  out  1  one-cycle pulse on frame misalignment
 overrun  out  1  sticky, window dropped because drain incomplete

Function
REQ-004 Receive FSM SHALL have states IDLE, SYNC_WAIT, ACCUM.
REQ-005 IDLE->SYNC_WAIT when en=1; any state->IDLE when en=0 (accumulators cleared, drain side unaffected).
REQ-006 SYNC_WAIT->ACCUM on the edge sampling frame_sync=1; that cycle's inputs are slot 0 of frame 0 and are accumulated.
REQ-007 In ACCUM, slot counter SHALL increment every cycle and wrap NUM_CH-1->0; frame counter increments on the wrap.
REQ-008 Per slot s, accumulators for channel s SHALL add read_out_I[0], read_out_I[1], read_out_Q[0], read_out_Q[1] to ev_I, pol_I, ev_Q, pol_Q respectively.
REQ-009 Accumulators SHALL saturate at 2^CNT_W-1, never wrap.
REQ-010 frame_sync=1 while slot counter != 0 in ACCUM SHALL pulse sync_err, clear all accumulators and frame counter, and realign slot counter so that cycle is slot 0 (accumulated); frame_sync=1 at slot 0 is normal.
REQ-011 Window end = last slot (NUM_CH-1) of frame win_len-1; at that edge, final-slot counts SHALL be included, all NUM_CH channel counts copied to the drain buffer if empty, accumulators and frame counter cleared; accumulation continues without gap.
REQ-012 If the drain buffer is not empty at window end, the window SHALL be discarded, overrun set, accumulation continues.
REQ-013 Drain side: states EMPTY, DRAIN; on snapshot, out_valid SHALL rise the next cycle with out_ch=0.
REQ-014 A record transfers when out_valid & out_ready at a rising edge; out_ch then increments; after out_ch=NUM_CH-1 transfers, buffer returns EMPTY and out_valid falls the next cycle.
REQ-015 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-016 Snapshot at the same edge the last record transfers SHALL be accepted (buffer counts as empty), no overrun.

Reset
REQ-017 rst=1 SHALL force: FSM IDLE, drain EMPTY, out_valid=0, out_ch=0, all out counts 0, sync_err=0, overrun=0, accumulators and counters 0.
REQ-018 rst mid-window or mid-drain SHALL discard all partial data; no record emitted after reset until a new complete window.
REQ-019 overrun SHALL clear only on rst.

Structure
REQ-020 Shared package SHALL hold state enums (IDLE/SYNC_WAIT/ACCUM, EMPTY/DRAIN) and the record field-width constants.
REQ-021 Sub-module sat_counter (CNT_W-bit saturating incrementer with sync clear) SHALL be instantiated 4*NUM_CH times.

Verification
REQ-022 NUM_CH=8, win_len=1, sync at cycle 0, read_out_I=2'b11 on slot 3 only -> one drain; record ch3 ev_I=1 pol_I=1, all others 0.
REQ-023 win_len=300, read_out_Q[0]=1 constant, CNT_W=8 -> every record ev_Q=255 (saturated), ev_I=0.
REQ-024 frame_sync asserted at slot 5 of frame 2 -> sync_err one-cycle pulse, next window counts start from that cycle as slot 0.
REQ-025 win_len=1, out_ready=0 for 20 cycles -> out_valid held, ch0 stable, overrun=1 after 2nd window end; first window's 8 records drain intact once out_ready=1.
REQ-026 out_ready toggled randomly, win_len=2 -> exactly 8 records per window, out_ch 0..7 in order, counts match reference model.
REQ-027 rst pulse mid-drain at record ch4 -> out_valid=0 next cycle, overrun=0, next window's record starts at ch0.
